// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS memory stage: FSM states, branch
// condition encodings, default datapath widths and the branch-condition helper.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    localparam logic [1:0] BR_EQ   = 2'd0;
    localparam logic [1:0] BR_LT   = 2'd1;
    localparam logic [1:0] BR_GT   = 2'd2;
    localparam logic [1:0] BR_NONE = 2'd3;

    typedef enum logic {
        IDLE,
        ACCESS
    } mem_state_t;

    function automatic logic branch_cond(input logic [1:0] br_type,
                                         input logic       zero,
                                         input logic       lt,
                                         input logic       gt);
        logic taken;
        taken = 1'b0;
        case (br_type)
            BR_EQ:   taken = zero;
            BR_LT:   taken = lt;
            BR_GT:   taken = gt;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: valid bit updates every cycle, payload fields only
// when load is asserted so a stalled stage keeps presenting its last result.
module mem_wb_reg
    import mips_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int RW = REG_W
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          load,
    input  logic          valid_in,
    input  logic          reg_write_in,
    input  logic          mem_to_reg_in,
    input  logic [DW-1:0] read_data_in,
    input  logic [DW-1:0] alu_result_in,
    input  logic [RW-1:0] write_reg_in,
    output logic          valid,
    output logic          reg_write,
    output logic          mem_to_reg,
    output logic [DW-1:0] read_data,
    output logic [DW-1:0] alu_result,
    output logic [RW-1:0] write_reg
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid      <= 1'b0;
            reg_write  <= 1'b0;
            mem_to_reg <= 1'b0;
            read_data  <= '0;
            alu_result <= '0;
            write_reg  <= '0;
        end else begin
            valid <= valid_in;
            if (load) begin
                reg_write  <= reg_write_in;
                mem_to_reg <= mem_to_reg_in;
                read_data  <= read_data_in;
                alu_result <= alu_result_in;
                write_reg  <= write_reg_in;
            end
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: branch resolution, data-memory req/ack handshake with upstream
// stall, and MEM/WB register. Define MEM_TIMEOUT_EN to abort hung accesses.
module mem_stage
    import mips_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int RW = REG_W
`ifdef MEM_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          ex_valid,
    input  logic          ex_zero,
    input  logic          ex_lt,
    input  logic          ex_gt,
    input  logic          ex_branch,
    input  logic [1:0]    ex_br_type,
    input  logic          ex_mem_write,
    input  logic          ex_mem_read,
    input  logic          ex_mem_to_reg,
    input  logic          ex_reg_write,
    input  logic [DW-1:0] ex_alu_result,
    input  logic [DW-1:0] ex_add_result,
    input  logic [DW-1:0] ex_store_data,
    input  logic [RW-1:0] ex_write_reg,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [DW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    input  logic          dmem_ack,
    input  logic [DW-1:0] dmem_rdata,
    output logic          pc_src,
    output logic [DW-1:0] branch_target,
    output logic          mem_stall,
    output logic          wb_valid,
    output logic          wb_reg_write,
    output logic          wb_mem_to_reg,
    output logic [DW-1:0] wb_read_data,
    output logic [DW-1:0] wb_alu_result,
    output logic [RW-1:0] wb_write_reg,
    output logic          mem_err
);

    mem_state_t    state;
    mem_state_t    state_next;
    logic          mem_op;
    logic          timeout_hit;
    logic          wb_load;
    logic          wb_valid_next;
    logic          wb_reg_write_next;
    logic [DW-1:0] wb_read_data_next;

    assign mem_op        = ex_valid & (ex_mem_read | ex_mem_write);
    assign branch_target = ex_add_result;
    assign pc_src        = (state == IDLE) & ex_valid & ex_branch &
                           branch_cond(ex_br_type, ex_zero, ex_lt, ex_gt);

    always_comb begin
        state_next        = state;
        mem_stall         = 1'b0;
        wb_load           = 1'b0;
        wb_valid_next     = 1'b0;
        wb_reg_write_next = ex_reg_write;
        wb_read_data_next = '0;
        case (state)
            IDLE: begin
                if (mem_op) begin
                    state_next = ACCESS;
                    mem_stall  = 1'b1;
                end else begin
                    wb_load       = 1'b1;
                    wb_valid_next = ex_valid;
                end
            end
            ACCESS: begin
                // The instruction is still held in EX/MEM, so its fields load directly on completion.
                mem_stall = ~(dmem_ack | timeout_hit);
                if (dmem_ack) begin
                    state_next        = IDLE;
                    wb_load           = 1'b1;
                    wb_valid_next     = 1'b1;
                    wb_read_data_next = dmem_we ? '0 : dmem_rdata;
                end else if (timeout_hit) begin
                    state_next        = IDLE;
                    wb_load           = 1'b1;
                    wb_valid_next     = 1'b1;
                    wb_reg_write_next = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
        end else begin
            state <= state_next;
            if ((state == IDLE) && mem_op) begin
                dmem_req   <= 1'b1;
                dmem_we    <= ex_mem_write;
                dmem_addr  <= ex_alu_result;
                dmem_wdata <= ex_store_data;
            end else if ((state == ACCESS) && (state_next == IDLE)) begin
                dmem_req <= 1'b0;
                dmem_we  <= 1'b0;
            end
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CW-1:0] access_cnt;

    assign timeout_hit = (state == ACCESS) && !dmem_ack &&
                         (access_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            access_cnt <= '0;
            mem_err    <= 1'b0;
        end else begin
            access_cnt <= (state == ACCESS) ? access_cnt + 1'b1 : '0;
            if (timeout_hit) begin
                mem_err <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign mem_err     = 1'b0;
`endif

    mem_wb_reg #(
        .DW(DW),
        .RW(RW)
    ) u_mem_wb_reg (
        .clock         (clock),
        .reset_n       (reset_n),
        .load          (wb_load),
        .valid_in      (wb_valid_next),
        .reg_write_in  (wb_reg_write_next),
        .mem_to_reg_in (ex_mem_to_reg),
        .read_data_in  (wb_read_data_next),
        .alu_result_in (ex_alu_result),
        .write_reg_in  (ex_write_reg),
        .valid         (wb_valid),
        .reg_write     (wb_reg_write),
        .mem_to_reg    (wb_mem_to_reg),
        .read_data     (wb_read_data),
        .alu_result    (wb_alu_result),
        .write_reg     (wb_write_reg)
    );

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: randomized instruction stream against a
// transaction-level model with a word memory; honours MEM_TIMEOUT_EN.
module tb_mem_stage;
    import mips_pkg::*;

    typedef struct {
        logic        valid;
        logic        branch;
        logic [1:0]  br_type;
        logic        zero;
        logic        lt;
        logic        gt;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        reg_write;
        logic [31:0] alu;
        logic [31:0] add;
        logic [31:0] store;
        logic [4:0]  wr;
        int          delay;
    } instr_t;

    typedef struct {
        logic        reg_write;
        logic        mem_to_reg;
        logic [31:0] read_data;
        logic [31:0] alu;
        logic [4:0]  wr;
    } wb_exp_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        ex_valid = 1'b0, ex_zero = 1'b0, ex_lt = 1'b0, ex_gt = 1'b0;
    logic        ex_branch = 1'b0;
    logic [1:0]  ex_br_type = BR_NONE;
    logic        ex_mem_write = 1'b0, ex_mem_read = 1'b0;
    logic        ex_mem_to_reg = 1'b0, ex_reg_write = 1'b0;
    logic [31:0] ex_alu_result = '0, ex_add_result = '0, ex_store_data = '0;
    logic [4:0]  ex_write_reg = '0;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        pc_src;
    logic [31:0] branch_target;
    logic        mem_stall;
    logic        wb_valid, wb_reg_write, wb_mem_to_reg;
    logic [31:0] wb_read_data, wb_alu_result;
    logic [4:0]  wb_write_reg;
    logic        mem_err;

    int checks = 0;
    int errors = 0;
    wb_exp_t     sbQueue[$];
    logic [31:0] memory[logic [31:0]];

    always #5 clock = ~clock;

    mem_stage #(
        .DW(32),
        .RW(5)
`ifdef MEM_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(4)
`endif
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .ex_valid(ex_valid), .ex_zero(ex_zero), .ex_lt(ex_lt), .ex_gt(ex_gt),
        .ex_branch(ex_branch), .ex_br_type(ex_br_type),
        .ex_mem_write(ex_mem_write), .ex_mem_read(ex_mem_read),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write),
        .ex_alu_result(ex_alu_result), .ex_add_result(ex_add_result),
        .ex_store_data(ex_store_data), .ex_write_reg(ex_write_reg),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .pc_src(pc_src), .branch_target(branch_target), .mem_stall(mem_stall),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
        .wb_read_data(wb_read_data), .wb_alu_result(wb_alu_result),
        .wb_write_reg(wb_write_reg), .mem_err(mem_err)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic expectTaken(input instr_t ins);
        if (!ins.valid || !ins.branch) return 1'b0;
        if (ins.br_type == 2'd0) return ins.zero;
        if (ins.br_type == 2'd1) return ins.lt;
        if (ins.br_type == 2'd2) return ins.gt;
        return 1'b0;
    endfunction

    function automatic instr_t blankInstr();
        instr_t ins;
        ins = '{valid: 1'b0, branch: 1'b0, br_type: 2'd3, zero: 1'b0, lt: 1'b0, gt: 1'b0,
                mem_read: 1'b0, mem_write: 1'b0, mem_to_reg: 1'b0, reg_write: 1'b0,
                alu: 32'h0, add: 32'h0, store: 32'h0, wr: 5'd0, delay: 0};
        return ins;
    endfunction

    task automatic driveInputs(input instr_t ins);
        ex_valid      = ins.valid;
        ex_branch     = ins.branch;
        ex_br_type    = ins.br_type;
        ex_zero       = ins.zero;
        ex_lt         = ins.lt;
        ex_gt         = ins.gt;
        ex_mem_read   = ins.mem_read;
        ex_mem_write  = ins.mem_write;
        ex_mem_to_reg = ins.mem_to_reg;
        ex_reg_write  = ins.reg_write;
        ex_alu_result = ins.alu;
        ex_add_result = ins.add;
        ex_store_data = ins.store;
        ex_write_reg  = ins.wr;
    endtask

    task automatic nextEdge();
        @(posedge clock);
        #2;
    endtask

    // Presents one instruction, plays the memory side if needed, and queues the expected MEM/WB record.
    task automatic applyStimulus(input instr_t ins);
        logic        is_mem;
        logic        is_wr;
        logic [31:0] rdata;
        driveInputs(ins);
        dmem_ack = 1'b0;
        #1;
        is_mem = ins.valid && (ins.mem_read || ins.mem_write);
        checkOutput("req_idle", 64'(dmem_req), 64'd0);
        checkOutput("pc_src", 64'(pc_src), 64'(expectTaken(ins)));
        checkOutput("branch_target", 64'(branch_target), 64'(ins.add));
        checkOutput("stall_issue", 64'(mem_stall), 64'(is_mem));
        if (!is_mem) begin
            if (ins.valid)
                sbQueue.push_back('{ins.reg_write, ins.mem_to_reg, 32'h0, ins.alu, ins.wr});
            nextEdge();
        end else begin
            is_wr = ins.mem_write;
            rdata = 32'h0;
            if (!is_wr) begin
                if (memory.exists(ins.alu)) rdata = memory[ins.alu];
                else begin
                    rdata = $urandom;
                    memory[ins.alu] = rdata;
                end
            end
            nextEdge();
            for (int i = 0; i < ins.delay; i++) begin
                @(negedge clock);
                checkOutput("req_held", 64'(dmem_req), 64'd1);
                checkOutput("we_held", 64'(dmem_we), 64'(is_wr));
                checkOutput("addr_held", 64'(dmem_addr), 64'(ins.alu));
                checkOutput("wdata_held", 64'(dmem_wdata), 64'(ins.store));
                checkOutput("stall_wait", 64'(mem_stall), 64'd1);
                nextEdge();
            end
            dmem_ack   = 1'b1;
            dmem_rdata = is_wr ? $urandom : rdata;
            #1;
            checkOutput("req_at_ack", 64'(dmem_req), 64'd1);
            checkOutput("addr_at_ack", 64'(dmem_addr), 64'(ins.alu));
            checkOutput("stall_at_ack", 64'(mem_stall), 64'd0);
            sbQueue.push_back('{ins.reg_write, ins.mem_to_reg, is_wr ? 32'h0 : rdata, ins.alu, ins.wr});
            if (is_wr) memory[ins.alu] = ins.store;
            nextEdge();
            dmem_ack = 1'b0;
        end
    endtask

    function automatic instr_t randomInstr();
        instr_t ins;
        int     kind;
        ins = blankInstr();
        kind = $urandom_range(0, 5);
        ins.zero  = 1'($urandom);
        ins.lt    = 1'($urandom);
        ins.gt    = 1'($urandom);
        ins.add   = $urandom;
        ins.alu   = 32'($urandom_range(0, 7)) << 2;
        ins.store = $urandom;
        ins.wr    = 5'($urandom);
        ins.delay = $urandom_range(0, 4);
        ins.valid = (kind != 0);
        case (kind)
            0: begin
                ins.branch    = 1'($urandom);
                ins.br_type   = 2'($urandom);
                ins.mem_read  = 1'($urandom);
                ins.mem_write = 1'($urandom);
                ins.reg_write = 1'($urandom);
            end
            1: ins.reg_write = 1'b1;
            2: begin
                ins.branch  = 1'b1;
                ins.br_type = 2'($urandom);
            end
            3: begin
                ins.mem_read   = 1'b1;
                ins.mem_to_reg = 1'b1;
                ins.reg_write  = 1'b1;
            end
            4: ins.mem_write = 1'b1;
            default: begin
                ins.mem_read  = 1'b1;
                ins.mem_write = 1'b1;
            end
        endcase
        return ins;
    endfunction

    // Monitor: every presented MEM/WB result must match the oldest expectation.
    always @(negedge clock) begin
        if (reset_n && wb_valid) begin
            if (sbQueue.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_wb: got wb_valid=1 alu=0x%0h, expected no result at %0t",
                         wb_alu_result, $time);
            end else begin
                wb_exp_t e;
                e = sbQueue.pop_front();
                checkOutput("wb_reg_write", 64'(wb_reg_write), 64'(e.reg_write));
                checkOutput("wb_mem_to_reg", 64'(wb_mem_to_reg), 64'(e.mem_to_reg));
                checkOutput("wb_read_data", 64'(wb_read_data), 64'(e.read_data));
                checkOutput("wb_alu_result", 64'(wb_alu_result), 64'(e.alu));
                checkOutput("wb_write_reg", 64'(wb_write_reg), 64'(e.wr));
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        instr_t ins;
        #1;
        checkOutput("rst_req", 64'(dmem_req), 64'd0);
        checkOutput("rst_we", 64'(dmem_we), 64'd0);
        checkOutput("rst_addr", 64'(dmem_addr), 64'd0);
        checkOutput("rst_wdata", 64'(dmem_wdata), 64'd0);
        checkOutput("rst_wb_valid", 64'(wb_valid), 64'd0);
        checkOutput("rst_wb_reg_write", 64'(wb_reg_write), 64'd0);
        checkOutput("rst_mem_err", 64'(mem_err), 64'd0);
        repeat (2) @(posedge clock);
        #2;
        reset_n = 1'b1;
        nextEdge();

        $display("[TB] directed: ALU op");
        ins = blankInstr();
        ins.valid = 1'b1; ins.reg_write = 1'b1; ins.alu = 32'h1234; ins.wr = 5'd5;
        applyStimulus(ins);

        $display("[TB] directed: load with 3-cycle ack delay");
        ins = blankInstr();
        ins.valid = 1'b1; ins.mem_read = 1'b1; ins.mem_to_reg = 1'b1; ins.reg_write = 1'b1;
        ins.alu = 32'h40; ins.wr = 5'd7; ins.delay = 3;
        memory[32'h40] = 32'hDEADBEEF;
        applyStimulus(ins);

        $display("[TB] directed: store");
        ins = blankInstr();
        ins.valid = 1'b1; ins.mem_write = 1'b1; ins.alu = 32'h80; ins.store = 32'hA5; ins.delay = 2;
        applyStimulus(ins);

        $display("[TB] directed: BR_LT taken then not taken");
        ins = blankInstr();
        ins.valid = 1'b1; ins.branch = 1'b1; ins.br_type = BR_LT; ins.lt = 1'b1; ins.add = 32'h200;
        applyStimulus(ins);
        ins.lt = 1'b0;
        applyStimulus(ins);

        $display("[TB] directed: reset during access");
        ins = blankInstr();
        ins.valid = 1'b1; ins.mem_read = 1'b1; ins.reg_write = 1'b1; ins.alu = 32'h44; ins.wr = 5'd9;
        driveInputs(ins);
        nextEdge();
        @(negedge clock);
        checkOutput("req_before_reset", 64'(dmem_req), 64'd1);
        reset_n = 1'b0;
        #1;
        checkOutput("req_after_reset", 64'(dmem_req), 64'd0);
        checkOutput("wb_valid_after_reset", 64'(wb_valid), 64'd0);
        nextEdge();
        driveInputs(blankInstr());
        reset_n    = 1'b1;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hBAD0BAD0;
        nextEdge();
        dmem_ack = 1'b0;
        @(negedge clock);
        checkOutput("late_ack_wb_valid", 64'(wb_valid), 64'd0);
        checkOutput("late_ack_req", 64'(dmem_req), 64'd0);
        nextEdge();

`ifdef MEM_TIMEOUT_EN
        begin
            int reqCycles;
            $display("[TB] directed: access timeout");
            ins = blankInstr();
            ins.valid = 1'b1; ins.mem_read = 1'b1; ins.mem_to_reg = 1'b1; ins.reg_write = 1'b1;
            ins.alu = 32'h60; ins.wr = 5'd3;
            driveInputs(ins);
            sbQueue.push_back('{1'b0, 1'b1, 32'h0, 32'h60, 5'd3});
            nextEdge();
            reqCycles = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clock);
                if (!dmem_req) break;
                reqCycles++;
            end
            driveInputs(blankInstr());
            checkOutput("timeout_cycles", 64'(reqCycles), 64'd4);
            checkOutput("mem_err_set", 64'(mem_err), 64'd1);
            nextEdge();
            nextEdge();
            checkOutput("mem_err_sticky", 64'(mem_err), 64'd1);
        end
`endif

        $display("[TB] random stream");
        for (int n = 0; n < 60; n++) begin
            applyStimulus(randomInstr());
        end
        driveInputs(blankInstr());
        repeat (3) nextEdge();
        checkOutput("scoreboard_drained", 64'(sbQueue.size()), 64'd0);
`ifndef MEM_TIMEOUT_EN
        checkOutput("mem_err_tied", 64'(mem_err), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
